// File: rtl/cv32e41s_obi_addr_phase.sv
// OBI address-phase stage for the cv32e41s load/store and fetch paths.
// A new transaction is passed straight through while the bus grants it in
// the same cycle. If the grant is withheld, the payload is captured and
// replayed from registers until it is granted, so that request and payload
// stay stable on the bus. A saturating counter tracks granted transactions
// still awaiting rvalid. New requests are throttled once that count reaches
// MAX_OUTSTANDING.

module cv32e41s_obi_addr_phase #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,

    input  logic                                 trans_valid_i,
    output logic                                 trans_ready_o,
    input  logic [31:0]                          trans_addr_i,
    input  logic                                 trans_we_i,
    input  logic [3:0]                           trans_be_i,
    input  logic [31:0]                          trans_wdata_i,
    input  logic                                 trans_integrity_i,

    output logic                                 obi_req_o,
    input  logic                                 obi_gnt_i,
    output logic [31:0]                          obi_addr_o,
    output logic                                 obi_we_o,
    output logic [3:0]                           obi_be_o,
    output logic [31:0]                          obi_wdata_o,
    output logic                                 obi_integrity_o,
    input  logic                                 obi_rvalid_i,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic {
        TRANSPARENT = 1'b0,
        REGISTERED  = 1'b1
    } state_e;

    state_e          state_q;
    state_e          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            limit;
    logic            capture;
    logic            bus_inc;

    logic [31:0]     addr_q;
    logic            we_q;
    logic [3:0]      be_q;
    logic [31:0]     wdata_q;
    logic            integrity_q;

    // A response arriving in the same cycle frees a slot, so it lifts the
    // limit immediately.
    assign limit = (cnt_q == MAX_CNT) && !obi_rvalid_i;

    // Pick the request, ready and payload source, and decide whether to
    // park the payload.
    always_comb begin
        state_d         = state_q;
        capture         = 1'b0;
        trans_ready_o   = 1'b0;
        obi_req_o       = 1'b0;
        obi_addr_o      = trans_addr_i;
        obi_we_o        = trans_we_i;
        obi_be_o        = trans_be_i;
        obi_wdata_o     = trans_wdata_i;
        obi_integrity_o = trans_integrity_i;

        unique case (state_q)
            TRANSPARENT: begin
                trans_ready_o = !limit;
                obi_req_o     = trans_valid_i && !limit;
                if (trans_valid_i && !limit && !obi_gnt_i) begin
                    capture = 1'b1;
                    state_d = REGISTERED;
                end
            end
            REGISTERED: begin
                // The request is held even if the limit would now apply,
                // because dropping it would break OBI address-phase stability.
                obi_req_o       = 1'b1;
                obi_addr_o      = addr_q;
                obi_we_o        = we_q;
                obi_be_o        = be_q;
                obi_wdata_o     = wdata_q;
                obi_integrity_o = integrity_q;
                if (obi_gnt_i) begin
                    state_d = TRANSPARENT;
                end
            end
            default: begin
                state_d = TRANSPARENT;
            end
        endcase
    end

    assign bus_inc = obi_req_o && obi_gnt_i;

    // Outstanding count: +1 per accepted address phase, -1 per response, and
    // no change when both happen. A response at zero is a bus error that is
    // reported further downstream, so the count stays at zero here.
    always_comb begin
        cnt_d = cnt_q;
        if (bus_inc && !obi_rvalid_i) begin
            cnt_d = cnt_q + CW'(1);
        end else if (obi_rvalid_i && !bus_inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TRANSPARENT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Payload holding registers, loaded only when a request is left waiting
    // for its grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            integrity_q <= 1'b0;
        end else if (capture) begin
            addr_q      <= trans_addr_i;
            we_q        <= trans_we_i;
            be_q        <= trans_be_i;
            wdata_q     <= trans_wdata_i;
            integrity_q <= trans_integrity_i;
        end
    end

    assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_cv32e41s_obi_addr_phase.sv
// Testbench for cv32e41s_obi_addr_phase (MAX_OUTSTANDING = 2).
// Each table row gives the inputs driven for one cycle and the outputs
// expected in that same cycle, before the clock edge. The expected record is
// queued when the row is driven and popped when the outputs are sampled.

module tb_cv32e41s_obi_addr_phase;

    logic        clk;
    logic        rst_n;
    logic        trans_valid;
    logic        trans_ready;
    logic [31:0] trans_addr;
    logic        trans_we;
    logic [3:0]  trans_be;
    logic [31:0] trans_wdata;
    logic        trans_integrity;
    logic        obi_req;
    logic        obi_gnt;
    logic [31:0] obi_addr;
    logic        obi_we;
    logic [3:0]  obi_be;
    logic [31:0] obi_wdata;
    logic        obi_integrity;
    logic        obi_rvalid;
    logic [1:0]  outstanding;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        integ;
        logic        gnt;
        logic        rvalid;
        logic        e_req;
        logic        e_ready;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_integ;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    cv32e41s_obi_addr_phase #(.MAX_OUTSTANDING(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .trans_valid_i     (trans_valid),
        .trans_ready_o     (trans_ready),
        .trans_addr_i      (trans_addr),
        .trans_we_i        (trans_we),
        .trans_be_i        (trans_be),
        .trans_wdata_i     (trans_wdata),
        .trans_integrity_i (trans_integrity),
        .obi_req_o         (obi_req),
        .obi_gnt_i         (obi_gnt),
        .obi_addr_o        (obi_addr),
        .obi_we_o          (obi_we),
        .obi_be_o          (obi_be),
        .obi_wdata_o       (obi_wdata),
        .obi_integrity_o   (obi_integrity),
        .obi_rvalid_i      (obi_rvalid),
        .outstanding_o     (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic v, input logic [31:0] a, input logic w, input logic [3:0] b,
        input logic [31:0] d, input logic i, input logic g, input logic r,
        input logic erq, input logic erd, input logic [31:0] ea, input logic ew,
        input logic [3:0] eb, input logic [31:0] ed, input logic ei, input logic [1:0] ec);
        vec_t t;
        t.valid = v;   t.addr = a;    t.we = w;      t.be = b;
        t.wdata = d;   t.integ = i;   t.gnt = g;     t.rvalid = r;
        t.e_req = erq; t.e_ready = erd; t.e_addr = ea; t.e_we = ew;
        t.e_be = eb;   t.e_wdata = ed; t.e_integ = ei; t.e_cnt = ec;
        return t;
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one row at the falling edge and queue its expectation.
    task automatic applyStimulus(input vec_t t);
        @(negedge clk);
        trans_valid     = t.valid;
        trans_addr      = t.addr;
        trans_we        = t.we;
        trans_be        = t.be;
        trans_wdata     = t.wdata;
        trans_integrity = t.integ;
        obi_gnt         = t.gnt;
        obi_rvalid      = t.rvalid;
        exp_q.push_back(t);
    endtask

    // Sample the outputs mid-cycle and compare them with the oldest expectation.
    task automatic checkOutput(input string tag);
        vec_t e;
        #2;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
        end else begin
            checks--;
            e = exp_q.pop_front();
            checkField({tag, " req"},       {31'd0, obi_req},       {31'd0, e.e_req});
            checkField({tag, " ready"},     {31'd0, trans_ready},   {31'd0, e.e_ready});
            checkField({tag, " addr"},      obi_addr,               e.e_addr);
            checkField({tag, " we"},        {31'd0, obi_we},        {31'd0, e.e_we});
            checkField({tag, " be"},        {28'd0, obi_be},        {28'd0, e.e_be});
            checkField({tag, " wdata"},     obi_wdata,              e.e_wdata);
            checkField({tag, " integrity"}, {31'd0, obi_integrity}, {31'd0, e.e_integ});
            checkField({tag, " outstanding"}, {30'd0, outstanding}, {30'd0, e.e_cnt});
        end
    endtask

    initial begin
        // Rows 0-8: back-to-back grants, limit, rvalid at full count,
        // draining, underflow and a stray grant.
        vecs.push_back(mk(1, 32'hA000_0000, 1, 4'b0011, 32'h0000_00A0, 1, 1, 0,  1, 1, 32'hA000_0000, 1, 4'b0011, 32'h0000_00A0, 1, 2'd0));
        vecs.push_back(mk(1, 32'hA000_0004, 0, 4'b1111, 32'h0000_00A1, 0, 1, 0,  1, 1, 32'hA000_0004, 0, 4'b1111, 32'h0000_00A1, 0, 2'd1));
        vecs.push_back(mk(1, 32'hA000_0008, 0, 4'b1111, 32'h0000_00A2, 0, 1, 0,  0, 0, 32'hA000_0008, 0, 4'b1111, 32'h0000_00A2, 0, 2'd2));
        vecs.push_back(mk(1, 32'hA000_000C, 1, 4'b1100, 32'h0000_00A3, 0, 1, 1,  1, 1, 32'hA000_000C, 1, 4'b1100, 32'h0000_00A3, 0, 2'd2));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 4'b0000, 32'h0000_0000, 0, 0, 1,  0, 1, 32'h0000_0000, 0, 4'b0000, 32'h0000_0000, 0, 2'd2));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 4'b0000, 32'h0000_0000, 0, 0, 1,  0, 1, 32'h0000_0000, 0, 4'b0000, 32'h0000_0000, 0, 2'd1));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 4'b0000, 32'h0000_0000, 0, 0, 1,  0, 1, 32'h0000_0000, 0, 4'b0000, 32'h0000_0000, 0, 2'd0));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 4'b0000, 32'h0000_0000, 0, 1, 0,  0, 1, 32'h0000_0000, 0, 4'b0000, 32'h0000_0000, 0, 2'd0));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 4'b0000, 32'h0000_0000, 0, 0, 0,  0, 1, 32'h0000_0000, 0, 4'b0000, 32'h0000_0000, 0, 2'd0));
        // Rows 9-15: grant withheld for three cycles while the upstream
        // payload changes, then granted and drained.
        vecs.push_back(mk(1, 32'h1000_0004, 1, 4'b1111, 32'h1111_1111, 0, 0, 0,  1, 1, 32'h1000_0004, 1, 4'b1111, 32'h1111_1111, 0, 2'd0));
        vecs.push_back(mk(1, 32'hDEAD_BEEF, 0, 4'b0001, 32'h2222_2222, 1, 0, 0,  1, 0, 32'h1000_0004, 1, 4'b1111, 32'h1111_1111, 0, 2'd0));
        vecs.push_back(mk(0, 32'hDEAD_BEEF, 0, 4'b0001, 32'h2222_2222, 1, 0, 0,  1, 0, 32'h1000_0004, 1, 4'b1111, 32'h1111_1111, 0, 2'd0));
        vecs.push_back(mk(0, 32'hDEAD_BEEF, 0, 4'b0001, 32'h2222_2222, 1, 1, 0,  1, 0, 32'h1000_0004, 1, 4'b1111, 32'h1111_1111, 0, 2'd0));
        vecs.push_back(mk(0, 32'hDEAD_BEEF, 0, 4'b0001, 32'h2222_2222, 1, 0, 0,  0, 1, 32'hDEAD_BEEF, 0, 4'b0001, 32'h2222_2222, 1, 2'd1));
        vecs.push_back(mk(0, 32'hDEAD_BEEF, 0, 4'b0001, 32'h2222_2222, 1, 0, 1,  0, 1, 32'hDEAD_BEEF, 0, 4'b0001, 32'h2222_2222, 1, 2'd1));
        vecs.push_back(mk(0, 32'hDEAD_BEEF, 0, 4'b0001, 32'h2222_2222, 1, 0, 0,  0, 1, 32'hDEAD_BEEF, 0, 4'b0001, 32'h2222_2222, 1, 2'd0));

        rst_n           = 1'b0;
        trans_valid     = 1'b0;
        trans_addr      = '0;
        trans_we        = 1'b0;
        trans_be        = '0;
        trans_wdata     = '0;
        trans_integrity = 1'b0;
        obi_gnt         = 1'b0;
        obi_rvalid      = 1'b0;

        // Reset state: the outputs are checked while reset is still asserted
        // and again after it is released.
        repeat (2) @(posedge clk);
        #2;
        checkField("reset req",         {31'd0, obi_req},     32'd0);
        checkField("reset ready",       {31'd0, trans_ready}, 32'd1);
        checkField("reset outstanding", {30'd0, outstanding}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        checkField("post-reset ready",       {31'd0, trans_ready}, 32'd1);
        checkField("post-reset outstanding", {30'd0, outstanding}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("row%0d", i));
        end

        // Reset during a waited grant with one transaction outstanding.
        applyStimulus(mk(1, 32'h2000_0000, 0, 4'b1111, 32'h0, 0, 1, 0,  1, 1, 32'h2000_0000, 0, 4'b1111, 32'h0, 0, 2'd0));
        checkOutput("rst-pre0");
        applyStimulus(mk(1, 32'h3000_0000, 0, 4'b1111, 32'h0, 0, 0, 0,  1, 1, 32'h3000_0000, 0, 4'b1111, 32'h0, 0, 2'd1));
        checkOutput("rst-pre1");
        @(negedge clk);
        trans_valid = 1'b0;
        trans_addr  = 32'h4000_0000;
        obi_gnt     = 1'b0;
        #1;
        checkField("registered req held", {31'd0, obi_req}, 32'd1);
        checkField("registered addr",     obi_addr,          32'h3000_0000);
        rst_n = 1'b0;
        #1;
        checkField("async reset req",         {31'd0, obi_req},     32'd0);
        checkField("async reset ready",       {31'd0, trans_ready}, 32'd1);
        checkField("async reset outstanding", {30'd0, outstanding}, 32'd0);
        @(negedge clk);
        obi_gnt = 1'b1;
        rst_n   = 1'b1;
        @(negedge clk);
        #2;
        checkField("post-release req",         {31'd0, obi_req},     32'd0);
        checkField("post-release outstanding", {30'd0, outstanding}, 32'd0);
        checkField("post-release addr",        obi_addr,             32'h4000_0000);
        obi_gnt = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cv32e41s_obi_addr_phase.md
CV32E41S_OBI_ADDR_PHASE -- requirements
Module: cv32e41s_obi_addr_phase

Interface
REQ-001 The block SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum number of granted OBI transactions awaiting rvalid (legal range 1..7).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port trans_valid_i, input, 1 bit: upstream transaction valid.
REQ-005 The block SHALL have port trans_ready_o, output, 1 bit: the block accepts the upstream transaction this cycle.
REQ-006 The block SHALL have ports trans_addr_i (input, 32 bits), trans_we_i (input, 1 bit), trans_be_i (input, 4 bits), trans_wdata_i (input, 32 bits) and trans_integrity_i (input, 1 bit): the transaction address, write enable, byte enables, write data and PMA integrity attribute.
REQ-007 The block SHALL have port obi_req_o, output, 1 bit: OBI address-phase request.
REQ-008 The block SHALL have port obi_gnt_i, input, 1 bit: OBI grant.
REQ-009 The block SHALL have ports obi_addr_o (output, 32 bits), obi_we_o (output, 1 bit), obi_be_o (output, 4 bits), obi_wdata_o (output, 32 bits) and obi_integrity_o (output, 1 bit): the OBI address-phase payload; obi_we_o and obi_integrity_o feed the downstream integrity FIFO's trans_we_i and trans_integrity_i.
REQ-010 The block SHALL have port obi_rvalid_i, input, 1 bit: OBI response valid.
REQ-011 The block SHALL have port outstanding_o, output, $clog2(MAX_OUTSTANDING+1) bits: the current outstanding-transaction count.

Function
REQ-012 The FSM SHALL have exactly two states: TRANSPARENT and REGISTERED.
REQ-013 The limit signal SHALL be defined as (outstanding_o == MAX_OUTSTANDING) && !obi_rvalid_i.
REQ-014 In TRANSPARENT, trans_ready_o SHALL be !limit.
REQ-015 In TRANSPARENT, obi_req_o SHALL be trans_valid_i && !limit.
REQ-016 In TRANSPARENT, the obi_* payload SHALL equal the trans_* inputs combinationally, with zero latency.
REQ-017 In TRANSPARENT, when trans_valid_i && trans_ready_o && !obi_gnt_i, the block SHALL capture the trans_* payload into registers and move to REGISTERED at the next edge.
REQ-018 In TRANSPARENT, when trans_valid_i && trans_ready_o && obi_gnt_i, the block SHALL stay in TRANSPARENT.
REQ-019 In REGISTERED, the block SHALL drive obi_req_o=1 and trans_ready_o=0, and the obi_* payload SHALL come only from the registers, stable until granted and independent of trans_* changes.
REQ-020 In REGISTERED, on obi_gnt_i=1 the block SHALL return to TRANSPARENT at the next edge; with obi_gnt_i=0 it SHALL stay in REGISTERED.
REQ-021 Once obi_req_o is asserted, it SHALL not deassert before obi_gnt_i, and the payload SHALL not change before obi_gnt_i (OBI address-phase stability).
REQ-022 The payload registers SHALL load only on the capture condition of REQ-017; otherwise they hold.
REQ-023 The counter SHALL increment on obi_req_o && obi_gnt_i, decrement on obi_rvalid_i, and hold when both or neither occur.
REQ-024 The counter SHALL saturate at 0: an rvalid with count 0 leaves it at 0 (the protocol error is flagged downstream).
REQ-025 The counter SHALL never exceed MAX_OUTSTANDING, because REQ-013 blocks new requests at the maximum.
REQ-026 At count == MAX_OUTSTANDING, an rvalid in the same cycle SHALL release the limit combinationally, so a new grant and the rvalid coincide with no change in count.
REQ-027 A limit raised while in REGISTERED SHALL NOT drop the pending request.
REQ-028 obi_gnt_i while obi_req_o=0 SHALL be ignored (no count change, no state change).

Reset
REQ-029 While rst_n=0, the state SHALL be TRANSPARENT, the counter 0 and the payload registers 0.
REQ-030 Out of reset, outputs SHALL be trans_ready_o=1, obi_req_o=0 (with trans_valid_i=0) and outstanding_o=0.
REQ-031 Reset asserted mid-transaction (REGISTERED or outstanding>0) SHALL abandon all state immediately and asynchronously.

Verification
REQ-032 Back-to-back transfers: trans_valid_i=1 and obi_gnt_i=1 for 2 cycles with MAX_OUTSTANDING=2 and no rvalid -> 2 grants, outstanding_o=2; the 3rd cycle shows obi_req_o=0 and trans_ready_o=0.
REQ-033 Waited grant: addr 0x1000_0004 with gnt=0 for 3 cycles while trans_addr_i changes to 0xDEAD_BEEF -> obi_addr_o stays 0x1000_0004 and obi_req_o stays 1; after gnt, state is TRANSPARENT and outstanding_o=1.
REQ-034 Full count with rvalid: outstanding_o=2, trans_valid_i=1, obi_rvalid_i=1, obi_gnt_i=1 in the same cycle -> request issued and outstanding_o remains 2.
REQ-035 Underflow: obi_rvalid_i=1 with outstanding_o=0 -> outstanding_o remains 0.
REQ-036 Reset in REGISTERED: rst_n pulsed low during a waited grant -> immediately obi_req_o=0, outstanding_o=0, trans_ready_o=1, with no spurious grant counted after release.
REQ-037 Payload pass-through: a granted store with we=1, be=4'b0011, integrity=1 in TRANSPARENT -> obi_we_o=1, obi_be_o=4'b0011, obi_integrity_o=1 in the same cycle.
